// File: rtl/cpu_pkg.sv
// Shared constants and types for the integer register file.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int unsigned ZERO_REG   = 31;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

endpackage

// File: rtl/decoder5_32.sv
// Write-address decoder: one-hot per-register write enables, XZR never enabled.
module decoder5_32
  import cpu_pkg::*;
(
  input  reg_idx_t              write_addr_i,
  input  logic                  write_en_i,
  output logic [NUM_REGS-1:0]   reg_we_c
);

  always_comb begin
    reg_we_c = '0;
    if (write_en_i) begin
      reg_we_c[write_addr_i] = 1'b1;
    end
    reg_we_c[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/reg_file_32x64.sv
// ARM64 integer register file: 32x64, two combinational read ports, one write port, X31 reads zero.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding to the read ports.
module reg_file_32x64
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  reg_idx_t read_addr_a,
  input  reg_idx_t read_addr_b,
  input  reg_idx_t write_addr,
  input  word_t    write_data,
  input  logic     write_en,
  output word_t    read_data_a,
  output word_t    read_data_b
);

  logic [NUM_REGS-1:0] reg_we;
  word_t               regs_q [NUM_REGS];

  decoder5_32 u_decoder (
    .write_addr_i (write_addr),
    .write_en_i   (write_en),
    .reg_we_c     (reg_we)
  );

  // Reset clears every entry and drops any write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_we[i]) begin
          regs_q[i] <= write_data;
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = write_en && !reset && (write_addr != ZERO_IDX);
`endif

  always_comb begin
    read_data_a = regs_q[read_addr_a];
    if (read_addr_a == ZERO_IDX) begin
      read_data_a = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (fwd_ok && (write_addr == read_addr_a)) begin
      read_data_a = write_data;
    end
`endif
  end

  always_comb begin
    read_data_b = regs_q[read_addr_b];
    if (read_addr_b == ZERO_IDX) begin
      read_data_b = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (fwd_ok && (write_addr == read_addr_b)) begin
      read_data_b = write_data;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_32x64.sv
// Self-checking bench for reg_file_32x64; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file_32x64;
  import cpu_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic     clk;
  logic     reset;
  reg_idx_t read_addr_a;
  reg_idx_t read_addr_b;
  reg_idx_t write_addr;
  word_t    write_data;
  logic     write_en;
  word_t    read_data_a;
  word_t    read_data_b;

  reg_file_32x64 dut (
    .clk         (clk),
    .reset       (reset),
    .read_addr_a (read_addr_a),
    .read_addr_b (read_addr_b),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .write_en    (write_en),
    .read_data_a (read_data_a),
    .read_data_b (read_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    logic     rst;
    logic     we;
    reg_idx_t wa;
    word_t    wd;
    reg_idx_t ra;
    reg_idx_t rb;
    logic     chk;
    word_t    exp_a;
    word_t    exp_b;
  } vec_t;

  typedef struct {
    string name;
    word_t exp_a;
    word_t exp_b;
  } exp_t;

  localparam word_t DEAD = 64'hDEAD_BEEF_0123_4567;
  localparam word_t ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [12];

  // One cycle: drive at negedge, sample mid-low-phase before the next posedge
  task automatic drive_cycle(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset       = v.rst;
    write_en    = v.we;
    write_addr  = v.wa;
    write_data  = v.wd;
    read_addr_a = v.ra;
    read_addr_b = v.rb;
    if (v.chk) begin
      e.name  = v.name;
      e.exp_a = v.exp_a;
      e.exp_b = v.exp_b;
      sb_q.push_back(e);
    end
    #2;
    if (v.chk) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s: scoreboard empty", v.name);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (read_data_a !== e.exp_a) begin
          errors++;
          $display("FAIL %s: read_data_a got %h expected %h", e.name, read_data_a, e.exp_a);
        end
        checks++;
        if (read_data_b !== e.exp_b) begin
          errors++;
          $display("FAIL %s: read_data_b got %h expected %h", e.name, read_data_b, e.exp_b);
        end
      end
    end
  endtask

  function automatic vec_t mk(string name, logic rst, logic we, reg_idx_t wa, word_t wd,
                              reg_idx_t ra, reg_idx_t rb, logic chk, word_t ea, word_t eb);
    vec_t v;
    v.name = name; v.rst = rst; v.we = we; v.wa = wa; v.wd = wd;
    v.ra = ra; v.rb = rb; v.chk = chk; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  initial begin
    vec_t v;
    reset       = 1'b1;
    write_en    = 1'b0;
    write_addr  = '0;
    write_data  = '0;
    read_addr_a = '0;
    read_addr_b = '0;

    vecs[0]  = mk("reset_cycle",    1, 0, 0,  0,     0,  5,  0, 0, 0);
    vecs[1]  = mk("after_reset",    0, 0, 0,  0,     0,  5,  1, 0, 0);
    vecs[2]  = mk("write_x3",       0, 1, 3,  DEAD,  3,  3,  1, BYP ? DEAD : 64'h0, BYP ? DEAD : 64'h0);
    vecs[3]  = mk("read_x3",        0, 0, 0,  0,     3,  3,  1, DEAD, DEAD);
    vecs[4]  = mk("write_x31",      0, 1, 31, ONES,  31, 31, 1, 0, 0);
    vecs[5]  = mk("read_x31",       0, 0, 0,  0,     31, 31, 1, 0, 0);
    vecs[6]  = mk("write_x7_1",     0, 1, 7,  64'h1, 7,  3,  1, BYP ? 64'h1 : 64'h0, DEAD);
    vecs[7]  = mk("raw_x7",         0, 1, 7,  64'h2, 7,  7,  1, BYP ? 64'h2 : 64'h1, BYP ? 64'h2 : 64'h1);
    vecs[8]  = mk("after_raw_x7",   0, 0, 0,  0,     7,  3,  1, 64'h2, DEAD);
    vecs[9]  = mk("reset_vs_write", 1, 1, 10, 64'hAB, 10, 7, 1, 0, 64'h2);
    vecs[10] = mk("x10_dropped",    0, 0, 0,  0,     10, 7,  1, 0, 0);
    vecs[11] = mk("x3_cleared",     0, 0, 0,  0,     3,  31, 1, 0, 0);

    for (int i = 0; i < 12; i++) begin
      drive_cycle(vecs[i]);
    end

    // Sweep: fill X0..X30, observing the write cycle on port A
    for (int i = 0; i < 31; i++) begin
      word_t val;
      val = 64'(i) * 64'h0101;
      v = mk($sformatf("sweep_wr_%0d", i), 0, 1, reg_idx_t'(i), val, reg_idx_t'(i), 31, 1,
             BYP ? val : 64'h0, 64'h0);
      drive_cycle(v);
    end
    for (int i = 0; i < 31; i++) begin
      v = mk($sformatf("sweep_rd_%0d", i), 0, 0, 0, 0, reg_idx_t'(i), reg_idx_t'(30 - i), 1,
             64'(i) * 64'h0101, 64'(30 - i) * 64'h0101);
      drive_cycle(v);
    end
    v = mk("sweep_x31", 0, 0, 0, 0, 31, 30, 1, 0, 64'(30) * 64'h0101);
    drive_cycle(v);

    // Write to XZR with a bypass-eligible address pattern must not forward
    v = mk("xzr_no_fwd", 0, 1, 31, ONES, 31, 5, 1, 0, 64'h0505);
    drive_cycle(v);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
